// File: rtl/reg_snapshot_reader.sv
// Streams a snapshot of the architectural register file (PC, instruction, x0..x31)
// over a valid/ready port, bypassing in-flight write-back so the snapshot matches its commit.
module reg_snapshot_reader #(
  parameter int ARCH_WIDTH      = 64,
  parameter int INSTR_WIDTH     = 32,
  parameter int INSTR_MEM_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [INSTR_MEM_WIDTH-1:0] start_pc,
  input  logic [INSTR_WIDTH-1:0]     start_instr,
  output logic                       busy,
  output logic [4:0]                 rf_raddr,
  input  logic [ARCH_WIDTH-1:0]      rf_rdata,
  input  logic                       wb_we,
  input  logic [4:0]                 wb_rd,
  input  logic [ARCH_WIDTH-1:0]      wb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_kind,
  output logic [4:0]                 out_idx,
  output logic [ARCH_WIDTH-1:0]      out_data,
  output logic                       out_last,
  output logic                       done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [1:0] KIND_PC    = 2'd0;
  localparam logic [1:0] KIND_INSTR = 2'd1;
  localparam logic [1:0] KIND_REG   = 2'd2;

  state_t                  state_r, state_s;
  logic [5:0]              cnt_r, cnt_s;
  logic [INSTR_WIDTH-1:0]  instr_r, instr_s;
  logic [1:0]              kind_r, kind_s;
  logic [4:0]              idx_r, idx_s;
  logic [ARCH_WIDTH-1:0]   data_r, data_s;
  logic                    last_r, last_s;
  logic                    done_r, done_s;
  logic                    hs_s;
  logic [4:0]              reg_idx_s;
  logic [ARCH_WIDTH-1:0]   reg_data_s;

  assign busy      = (state_r == EMIT);
  assign out_valid = (state_r == EMIT);
  assign out_kind  = kind_r;
  assign out_idx   = idx_r;
  assign out_data  = data_r;
  assign out_last  = last_r;
  assign done      = done_r;
  assign hs_s      = (state_r == EMIT) && out_ready;

  // Register selected for the next load, plus write-back bypass; x0 is hardwired to zero.
  always_comb begin
    reg_idx_s  = cnt_r[4:0] - 5'd1;
    reg_data_s = rf_rdata;
    if ((cnt_r >= 6'd1) && (cnt_r <= 6'd32)) begin
      rf_raddr = reg_idx_s;
    end else begin
      rf_raddr = 5'd0;
    end
    if (reg_idx_s == 5'd0) begin
      reg_data_s = '0;
    end else if (wb_we && (wb_rd == reg_idx_s)) begin
      reg_data_s = wb_data;
    end else begin
      reg_data_s = rf_rdata;
    end
  end

  // Next-state and next-beat selection; out_* only change on start or on a handshake.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    instr_s = instr_r;
    kind_s  = kind_r;
    idx_s   = idx_r;
    data_s  = data_r;
    last_s  = last_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          instr_s = start_instr;
          data_s  = ARCH_WIDTH'(start_pc);
          kind_s  = KIND_PC;
          idx_s   = 5'd0;
          last_s  = 1'b0;
          cnt_s   = 6'd0;
          state_s = EMIT;
        end else begin
          state_s = IDLE;
        end
      end
      EMIT: begin
        if (hs_s) begin
          if (cnt_r == 6'd33) begin
            state_s = IDLE;
            done_s  = 1'b1;
            cnt_s   = 6'd0;
            last_s  = 1'b0;
          end else if (cnt_r == 6'd0) begin
            cnt_s  = cnt_r + 6'd1;
            kind_s = KIND_INSTR;
            idx_s  = 5'd0;
            data_s = ARCH_WIDTH'(instr_r);
            last_s = 1'b0;
          end else begin
            cnt_s  = cnt_r + 6'd1;
            kind_s = KIND_REG;
            idx_s  = reg_idx_s;
            data_s = reg_data_s;
            last_s = (reg_idx_s == 5'd31);
          end
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
      instr_r <= '0;
      kind_r  <= 2'd0;
      idx_r   <= 5'd0;
      data_r  <= '0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      instr_r <= instr_s;
      kind_r  <= kind_s;
      idx_r   <= idx_s;
      data_r  <= data_s;
      last_r  <= last_s;
      done_r  <= done_s;
    end
  end

endmodule

// File: tb/tb_reg_snapshot_reader.sv
// Scoreboard bench for reg_snapshot_reader: a table of snapshot scenarios plus
// hand-written sequences for ignored starts and reset while stalled.
module tb_reg_snapshot_reader;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  idx;
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    int          ready_pct;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [63:0] exp_rd_data;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] start_pc = '0;
  logic [31:0] start_instr = '0;
  logic        busy;
  logic [4:0]  rf_raddr;
  logic [63:0] rf_rdata;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [63:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_kind;
  logic [4:0]  out_idx;
  logic [63:0] out_data;
  logic        out_last;
  logic        done;

  logic [63:0] rf_mem [32];
  beat_t       sb [$];
  vec_t        vecs [5];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ready_pct = 100;
  bit          ready_manual = 1'b0;
  int          cyc = 0;
  int          beats_seen = 0;
  int          done_seen = 0;
  int          done_cyc = 0;
  bit          stalled_prev = 1'b0;
  beat_t       held;

  reg_snapshot_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .start_instr(start_instr), .busy(busy), .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_idx(out_idx), .out_data(out_data), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;
  assign rf_rdata = rf_mem[rf_raddr];

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready generator
  always begin
    @(posedge clk);
    #1;
    if (!ready_manual) out_ready = ($urandom_range(99) < ready_pct);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard pops on handshake, stall stability check
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        check("stall_hold", {out_valid, out_kind, out_idx, out_data, out_last},
              {1'b1, held.kind, held.idx, held.data, held.last});
      end
      if (out_valid && out_ready) begin
        beats_seen++;
        if (sb.size() == 0) begin
          check("unexpected_beat", {out_kind, out_idx, out_data, out_last}, '0);
        end else begin
          check("beat", {out_kind, out_idx, out_data, out_last}, sb.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
      stalled_prev = out_valid && !out_ready;
      held = '{kind: out_kind, idx: out_idx, data: out_data, last: out_last};
    end
  end

  task automatic push_expected(input vec_t v);
    logic [63:0] d;
    sb.push_back('{kind: 2'd0, idx: 5'd0, data: v.pc, last: 1'b0});
    sb.push_back('{kind: 2'd1, idx: 5'd0, data: {32'd0, v.instr}, last: 1'b0});
    for (int i = 0; i < 32; i++) begin
      if (i == 0) d = 64'd0;
      else if (v.wb_en && (i == int'(v.wb_rd))) d = v.exp_rd_data;
      else d = rf_mem[i];
      sb.push_back('{kind: 2'd2, idx: 5'(i), data: d, last: (i == 31)});
    end
  endtask

  task automatic pulse_start(input vec_t v, output int t0);
    start_pc = v.pc;
    start_instr = v.instr;
    start = 1'b1;
    push_expected(v);
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic finish_stream(input string name, input int b0, input int d0);
    int k;
    k = 0;
    while (done_seen == d0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_count"}, done_seen - d0, 1);
    check({name, "_beat_count"}, beats_seen - b0, 34);
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_idle"}, {busy, out_valid}, 2'b00);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int t0, b0, d0;
    string name;
    name = $sformatf("vec%0d", n);
    ready_pct = v.ready_pct;
    wb_we = v.wb_en;
    wb_rd = v.wb_rd;
    wb_data = v.wb_data;
    b0 = beats_seen;
    d0 = done_seen;
    pulse_start(v, t0);
    finish_stream(name, b0, d0);
    if (v.exp_lat != 0) check({name, "_done_latency"}, done_cyc - t0, v.exp_lat);
    wb_we = 1'b0;
  endtask

  initial begin
    vec_t v;
    int t0, b0, d0;

    vecs[0] = '{64'h8000_0000, 32'h0010_0093, 100, 1'b0, 5'd0,  64'd0, 64'd0, 34};
    vecs[1] = '{64'h8000_0000, 32'h0010_0093, 50,  1'b0, 5'd0,  64'd0, 64'd0, 0};
    vecs[2] = '{64'h8000_0004, 32'hDEAD_BEEF, 100, 1'b1, 5'd5,  64'hDEAD, 64'hDEAD, 34};
    vecs[3] = '{64'h8000_0008, 32'h0000_0013, 70,  1'b1, 5'd0,  64'hFFFF, 64'd0, 0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF, 30, 1'b1, 5'd31,
                64'hA5A5_5A5A_0123_4567, 64'hA5A5_5A5A_0123_4567, 0};

    rf_mem[0] = 64'd0;
    for (int i = 1; i < 32; i++) rf_mem[i] = 64'h10 + 64'(i);

    #12;
    check("reset_state", {busy, out_valid, out_kind, out_idx, out_data, out_last, done, rf_raddr},
          '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Starts mid-stream and coinciding with the final handshake are ignored
    v = vecs[0];
    ready_pct = 100;
    b0 = beats_seen;
    d0 = done_seen;
    pulse_start(v, t0);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 100 && !(out_valid && out_last); k++) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_cycle_not_busy", {done, busy}, 2'b10);
    finish_stream("ignore_start", b0, d0);

    // Asynchronous reset while stalled on x7
    ready_manual = 1'b1;
    out_ready = 1'b1;
    v = vecs[0];
    pulse_start(v, t0);
    for (int k = 0; k < 100 && !(out_valid && out_kind == 2'd2 && out_idx == 5'd7); k++) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    check("stalled_on_x7", {out_valid, out_kind, out_idx, out_data}, {1'b1, 2'd2, 5'd7, 64'h17});
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", {busy, out_valid, out_kind, out_idx, out_data, out_last, done, rf_raddr},
          '0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_manual = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_idle", {busy, out_valid}, 2'b00);
    run_vec(9, vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
